axis_pbs_bridge: RTL and testbench

//  AXIS-to-PBS bridge: converts an AXI4-Stream packet (metadata in tuser) into Packet Bus words for legacy PBS pipeline stages.

---
 rtl/axis_pbs_bridge_if.sv | 27 ++
 rtl/axis_pbs_bridge.sv | 128 ++++++++++++
 tb/tb_axis_pbs_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pbs_bridge_if.sv
// Bundles the AXI4-Stream input and the Packet Bus output of the AXIS-to-PBS bridge.
// The bridge uses the slave modport; the stream source / PBS sink side uses master.
interface axis_pbs_bridge_if #(
    parameter int DW = 64,
    parameter int UW = 128
);
    logic [DW-1:0]   axis_tdata;
    logic [DW/8-1:0] axis_tstrb;
    logic [UW-1:0]   axis_tuser;
    logic            axis_tvalid;
    logic            axis_tready;
    logic            axis_tlast;
    logic [DW-1:0]   pbs_data;
    logic [DW/8-1:0] pbs_ctrl;
    logic            pbs_wr;
    logic            pbs_rdy;

    modport slave (
        input  axis_tdata, axis_tstrb, axis_tuser, axis_tvalid, axis_tlast, pbs_rdy,
        output axis_tready, pbs_data, pbs_ctrl, pbs_wr
    );

    modport master (
        output axis_tdata, axis_tstrb, axis_tuser, axis_tvalid, axis_tlast, pbs_rdy,
        input  axis_tready, pbs_data, pbs_ctrl, pbs_wr
    );
endinterface

// File: rtl/axis_pbs_bridge.sv
// AXIS-to-PBS bridge: emits one module-header word per packet, then the packet's
// byte-reversed payload words, the last one tagged with a one-hot end-of-packet ctrl.
module axis_pbs_bridge #(
    parameter int C_AXIS_DATA_WIDTH   = 64,
    parameter int C_AXIS_USER_WIDTH   = 128,
    parameter int NUM_QUEUES          = 8,
    parameter int NUM_QUEUES_WIDTH    = $clog2(NUM_QUEUES),
    parameter int C_PBS_SRC_PORT_POS  = 16,
    parameter int C_PBS_DST_PORT_POS  = 48,
    parameter int C_PBS_IOQ_STAGE_NUM = 'hFF
) (
    input  logic              clk,
    input  logic              reset,
    axis_pbs_bridge_if.slave  bus
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int KW = $clog2(NB);
    localparam logic [KW-1:0] MAX_K = KW'(NB - 1);

    typedef enum logic {S_HEADER, S_PAYLOAD} state_t;

    state_t                r_state_reg;
    state_t                w_state_next;
    logic                  r_wr_reg;
    logic                  w_wr_next;
    logic [DW-1:0]         r_data_reg;
    logic [DW-1:0]         w_data_next;
    logic [NB-1:0]         r_ctrl_reg;
    logic [NB-1:0]         w_ctrl_next;
    logic                  w_tready;
    logic                  w_accept;
    logic [DW-1:0]         w_rev_data;
    logic [DW-1:0]         w_header;
    logic [NUM_QUEUES_WIDTH-1:0] w_src_idx;
    logic [KW-1:0]         w_last_k;
    logic [NB-1:0]         w_last_ctrl;
    logic                  w_unused;

    // Only the low 32 metadata bits carry meaning; the rest is ignored on purpose.
    assign w_unused = ^bus.axis_tuser;

    // PBS byte order is the mirror of the wire order.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_rev
            assign w_rev_data[gi*8 +: 8] = bus.axis_tdata[(NB-1-gi)*8 +: 8];
        end
    endgenerate

    // Descending scan so the lowest set bit of the src one-hot wins.
    always_comb begin
        w_src_idx = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (bus.axis_tuser[16 + i]) begin
                w_src_idx = NUM_QUEUES_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_header = '0;
        w_header[15:0] = bus.axis_tuser[15:0];
        w_header[C_PBS_SRC_PORT_POS +: NUM_QUEUES_WIDTH] = w_src_idx;
        w_header[C_PBS_DST_PORT_POS +: NUM_QUEUES] = bus.axis_tuser[24 +: NUM_QUEUES];
    end

    // Highest valid byte k maps to ctrl bit NB-1-k; an empty strobe behaves like k=0.
    always_comb begin
        w_last_k = '0;
        for (int i = 0; i < NB; i++) begin
            if (bus.axis_tstrb[i]) begin
                w_last_k = KW'(i);
            end
        end
        w_last_ctrl = NB'(1) << (MAX_K - w_last_k);
    end

    assign w_accept = bus.axis_tvalid & bus.pbs_rdy;

    always_comb begin
        w_state_next = r_state_reg;
        w_wr_next    = 1'b0;
        w_data_next  = r_data_reg;
        w_ctrl_next  = r_ctrl_reg;
        w_tready     = 1'b0;
        case (r_state_reg)
            S_HEADER: begin
                if (w_accept) begin
                    w_wr_next    = 1'b1;
                    w_data_next  = w_header;
                    w_ctrl_next  = NB'(C_PBS_IOQ_STAGE_NUM);
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_tready = bus.pbs_rdy;
                if (w_accept) begin
                    w_wr_next   = 1'b1;
                    w_data_next = w_rev_data;
                    w_ctrl_next = bus.axis_tlast ? w_last_ctrl : '0;
                    if (bus.axis_tlast) begin
                        w_state_next = S_HEADER;
                    end
                end
            end
            default: w_state_next = S_HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg <= S_HEADER;
            r_wr_reg    <= 1'b0;
            r_data_reg  <= '0;
            r_ctrl_reg  <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_wr_reg    <= w_wr_next;
            r_data_reg  <= w_data_next;
            r_ctrl_reg  <= w_ctrl_next;
        end
    end

    assign bus.axis_tready = w_tready;
    assign bus.pbs_wr      = r_wr_reg;
    assign bus.pbs_data    = r_data_reg;
    assign bus.pbs_ctrl    = r_ctrl_reg;
endmodule

// File: tb/tb_axis_pbs_bridge.sv
// Bench for axis_pbs_bridge: table-driven packets with a write scoreboard,
// plus hand-written stall, back-to-back and mid-packet reset sequences.
module tb_axis_pbs_bridge;
    typedef struct { logic [127:0] tuser; logic [63:0] hdr; } hdr_vec_t;
    typedef struct { logic [7:0] tstrb; logic [7:0] ctrl; } strb_vec_t;
    typedef struct { logic [63:0] data; logic [7:0] ctrl; } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_wr = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic rdy_at_edge = 1'b1;
    int   wr_log [0:1023];
    word_t sb_q [$];
    hdr_vec_t  hdr_tab [4];
    strb_vec_t strb_tab [9];

    axis_pbs_bridge_if #(.DW(64), .UW(128)) bus ();

    axis_pbs_bridge #(
        .C_AXIS_DATA_WIDTH(64),
        .C_AXIS_USER_WIDTH(128),
        .NUM_QUEUES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdy_at_edge <= bus.pbs_rdy;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
        return r;
    endfunction

    // Scoreboard consumer: every PBS write must match the next expected word.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pbs_wr) begin
                word_t e;
                if (n_wr < 1024) wr_log[n_wr] = cyc;
                n_wr++;
                check(rdy_at_edge, "wr_after_rdy_low", 64'(bus.pbs_wr), 64'(0));
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_write", bus.pbs_data, 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check(bus.pbs_data == e.data, "pbs_data", bus.pbs_data, e.data);
                    check(bus.pbs_ctrl == e.ctrl, "pbs_ctrl", 64'(bus.pbs_ctrl), 64'(e.ctrl));
                    $display("write %0d: data=%h ctrl=%h", n_wr, bus.pbs_data, bus.pbs_ctrl);
                end
            end
            if (!bus.pbs_rdy) begin
                check(!bus.axis_tready, "tready_while_rdy_low", 64'(bus.axis_tready), 64'(0));
            end
        end
    end

    task automatic wait_ready();
        int c = 0;
        @(negedge clk);
        while (!bus.axis_tready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!bus.axis_tready) check(1'b0, "tready_timeout", 64'(c), 64'(100));
    endtask

    task automatic drain();
        int c = 0;
        while (sb_q.size() != 0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check(sb_q.size() == 0, "drain_pending", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic send_pkt(input hdr_vec_t hv, input int nbeats, input logic [7:0] last_strb,
                            input logic [7:0] last_ctrl);
        logic [63:0] d;
        bit last;
        sb_q.push_back('{hv.hdr, 8'hFF});
        for (int b = 0; b < nbeats; b++) begin
            last = (b == nbeats - 1);
            d = {$urandom, $urandom};
            sb_q.push_back('{bswap(d), last ? last_ctrl : 8'h00});
            bus.axis_tdata  = d;
            bus.axis_tuser  = hv.tuser;
            bus.axis_tstrb  = last ? last_strb : 8'($urandom);
            bus.axis_tlast  = last;
            bus.axis_tvalid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
        end
        bus.axis_tvalid = 1'b0;
        bus.axis_tlast  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n_drop;
        logic [63:0] d;
        hdr_tab[0] = '{{{3{32'h5AA5_C33C}}, 8'h10, 8'h04, 16'h0014}, 64'h0010_0000_0002_0014};
        hdr_tab[1] = '{{{3{32'h5AA5_C33C}}, 8'h01, 8'h00, 16'h0040}, 64'h0001_0000_0000_0040};
        hdr_tab[2] = '{{{3{32'h5AA5_C33C}}, 8'hFF, 8'h0A, 16'h0100}, 64'h00FF_0000_0001_0100};
        hdr_tab[3] = '{{{3{32'h5AA5_C33C}}, 8'h80, 8'h80, 16'hFFFF}, 64'h0080_0000_0007_FFFF};
        strb_tab[0] = '{8'h01, 8'h80};
        strb_tab[1] = '{8'h03, 8'h40};
        strb_tab[2] = '{8'h07, 8'h20};
        strb_tab[3] = '{8'h0F, 8'h10};
        strb_tab[4] = '{8'h1F, 8'h08};
        strb_tab[5] = '{8'h3F, 8'h04};
        strb_tab[6] = '{8'h7F, 8'h02};
        strb_tab[7] = '{8'hFF, 8'h01};
        strb_tab[8] = '{8'h00, 8'h80};

        bus.axis_tdata  = '0;
        bus.axis_tstrb  = '0;
        bus.axis_tuser  = '0;
        bus.axis_tvalid = 1'b0;
        bus.axis_tlast  = 1'b0;
        bus.pbs_rdy     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(bus.pbs_wr == 1'b0, "reset_wr", 64'(bus.pbs_wr), 64'(0));
        check(bus.pbs_data == 64'h0, "reset_data", bus.pbs_data, 64'h0);
        check(bus.pbs_ctrl == 8'h0, "reset_ctrl", 64'(bus.pbs_ctrl), 64'h0);
        check(bus.axis_tready == 1'b0, "reset_tready", 64'(bus.axis_tready), 64'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // 3-beat packet, last strobe 0F
        send_pkt(hdr_tab[0], 3, 8'h0F, 8'h10);
        drain();

        // header field table
        for (int i = 1; i < 4; i++) begin
            send_pkt(hdr_tab[i], 2, 8'hFF, 8'h01);
        end
        drain();

        // last-beat strobe sweep
        for (int i = 0; i < 9; i++) begin
            send_pkt(hdr_tab[i % 4], 1, strb_tab[i].tstrb, strb_tab[i].ctrl);
        end
        drain();

        // back-to-back 1-beat packets: four writes on consecutive cycles
        n0 = n_wr;
        send_pkt(hdr_tab[1], 1, 8'h01, 8'h80);
        send_pkt(hdr_tab[2], 1, 8'h03, 8'h40);
        drain();
        check(n_wr - n0 == 4, "b2b_write_count", 64'(n_wr - n0), 64'(4));
        if (n_wr - n0 == 4 && n0 + 3 < 1024)
            check(wr_log[n0+3] - wr_log[n0] == 3, "b2b_cycle_span",
                  64'(wr_log[n0+3] - wr_log[n0]), 64'(3));

        // stall: pbs_rdy low for 4 cycles during payload beat 2
        n0 = n_wr;
        fork
            send_pkt(hdr_tab[0], 4, 8'h07, 8'h20);
            begin
                int c = 0;
                do begin
                    @(posedge clk);
                    #1;
                    c++;
                end while (n_wr < n0 + 2 && c < 60);
                bus.pbs_rdy = 1'b0;
                n_drop = n_wr;
                repeat (4) @(posedge clk);
                #1;
                check(n_wr - n_drop <= 1, "stall_inflight", 64'(n_wr - n_drop), 64'(1));
                bus.pbs_rdy = 1'b1;
            end
        join
        drain();
        check(n_wr - n0 == 5, "stall_write_count", 64'(n_wr - n0), 64'(5));

        // reset after first payload beat
        d = {$urandom, $urandom};
        sb_q.push_back('{hdr_tab[3].hdr, 8'hFF});
        sb_q.push_back('{bswap(d), 8'h00});
        bus.axis_tdata  = d;
        bus.axis_tuser  = hdr_tab[3].tuser;
        bus.axis_tstrb  = 8'hFF;
        bus.axis_tlast  = 1'b0;
        bus.axis_tvalid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.axis_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(bus.pbs_wr == 1'b0, "reset_mid_wr", 64'(bus.pbs_wr), 64'(0));
        check(bus.axis_tready == 1'b0, "reset_mid_header_state", 64'(bus.axis_tready), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pkt(hdr_tab[2], 2, 8'h3F, 8'h04);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
